peripheral_spram_wb_slave: RTL and testbench

Wishbone B3 responder (slave) backed by a single-port synchronous RAM. It is the target side for the team's Wishbone bus functional model, which acts as the initiator. It serves classic single cycles and registered-feedback incrementing bursts (linear and wrapped), with byte-lane writes and error response on out-of-range addresses. It sits on the peripheral bus as the SPRAM memory endpoint.

---
 rtl/peripheral_spram_wb_slave_if.sv | 37 +++
 rtl/peripheral_spram_wb_slave.sv | 179 +++++++++++++++++
 tb/tb_peripheral_spram_wb_slave.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/peripheral_spram_wb_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_spram_wb_slave_if
// Description : Wishbone B3 bus bundle between the initiator BFM and the
//               SPRAM responder. Signal names keep the slave-side view.
// Revision    : 1.0 - initial release
// ============================================================================
interface peripheral_spram_wb_slave_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   wb_adr_i;
    logic [DW-1:0]   wb_dat_i;
    logic [DW/8-1:0] wb_sel_i;
    logic            wb_we_i;
    logic            wb_cyc_i;
    logic            wb_stb_i;
    logic [2:0]      wb_cti_i;
    logic [1:0]      wb_bte_i;
    logic [DW-1:0]   wb_dat_o;
    logic            wb_ack_o;
    logic            wb_err_o;
    logic            wb_rty_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i,
               wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i,
               wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );
endinterface
`default_nettype wire

// File: rtl/peripheral_spram_wb_slave.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_spram_wb_slave
// Description : Wishbone B3 responder backed by a single-port synchronous RAM.
//               Classic cycles and registered-feedback incrementing bursts
//               (linear, wrap-4/8/16), byte-lane writes, error termination
//               for word indices at or beyond DEPTH.
// Revision    : 1.0 - initial release
// ============================================================================
module peripheral_spram_wb_slave #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 256
) (
    input  wire logic                  wb_clk_i,
    input  wire logic                  wb_rst_i,
    peripheral_spram_wb_slave_if.slave wb
);
    localparam int c_WB = $clog2(DW / 8);
    localparam int c_IW = AW - c_WB;
    localparam int c_MA = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_IW-1:0] c_DEPTH_IDX = c_IW'(DEPTH);
    localparam logic [c_IW-1:0] c_ONE       = {{(c_IW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CLASSIC = 2'd1,
        S_BURST   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [c_IW-1:0]  r_baddr;
    logic [c_IW-1:0]  w_baddr_nx;
    logic             r_ack;
    logic             w_ack_nx;
    logic             r_err;
    logic             w_err_nx;
    logic [DW-1:0]    r_dat;
    logic             w_rd_en;
    logic [c_MA-1:0]  w_rd_addr;

    logic [DW-1:0]    r_mem [DEPTH];

    logic             w_req;
    logic [c_IW-1:0]  w_idx;
    logic             w_oor;
    logic [c_IW-1:0]  w_inc;
    logic [c_IW-1:0]  w_wrap_mask;
    logic [c_IW-1:0]  w_next;
    logic             w_next_oor;
    logic             w_we;
    logic             w_unused;

    assign w_req = wb.wb_cyc_i & wb.wb_stb_i;
    assign w_idx = wb.wb_adr_i[AW-1:c_WB];
    assign w_oor = (w_idx >= c_DEPTH_IDX);

    // Byte-offset address bits are intentionally ignored.
    assign w_unused = ^wb.wb_adr_i;

    // Burst address successor: linear increment or wrap within an n-word block.
    always_comb begin
        w_inc       = r_baddr + c_ONE;
        w_wrap_mask = '0;
        case (wb.wb_bte_i)
            2'b01:   w_wrap_mask = c_IW'(3);
            2'b10:   w_wrap_mask = c_IW'(7);
            2'b11:   w_wrap_mask = c_IW'(15);
            default: w_wrap_mask = '0;
        endcase
        if (wb.wb_bte_i == 2'b00) begin
            w_next = w_inc;
        end else begin
            w_next = (r_baddr & ~w_wrap_mask) | (w_inc & w_wrap_mask);
        end
        w_next_oor = (w_next >= c_DEPTH_IDX);
    end

    // A beat is written on the edge that completes it (ack high, strobe held).
    assign w_we = r_ack & wb.wb_cyc_i & wb.wb_stb_i & wb.wb_we_i;

    // Next-state, termination and read-address selection.
    always_comb begin
        w_state_nx = r_state;
        w_baddr_nx = r_baddr;
        w_ack_nx   = 1'b0;
        w_err_nx   = 1'b0;
        w_rd_en    = 1'b0;
        w_rd_addr  = r_baddr[c_MA-1:0];
        case (r_state)
            S_IDLE: begin
                if (w_req && !r_ack && !r_err) begin
                    w_baddr_nx = w_idx;
                    if (w_oor) begin
                        w_err_nx   = 1'b1;
                        w_state_nx = S_CLASSIC;
                    end else begin
                        w_ack_nx   = 1'b1;
                        w_rd_en    = 1'b1;
                        w_rd_addr  = w_idx[c_MA-1:0];
                        w_state_nx = (wb.wb_cti_i == 3'b010) ? S_BURST : S_CLASSIC;
                    end
                end
            end
            S_CLASSIC: begin
                // Single-cycle termination, then a mandatory low cycle in IDLE.
                w_state_nx = S_IDLE;
            end
            S_BURST: begin
                if (!wb.wb_cyc_i) begin
                    w_state_nx = S_IDLE;
                end else if (!wb.wb_stb_i) begin
                    // Wait state: drop ack, hold the beat address.
                    w_state_nx = S_BURST;
                end else if (r_ack) begin
                    if (wb.wb_cti_i == 3'b111) begin
                        w_state_nx = S_IDLE;
                    end else begin
                        w_baddr_nx = w_next;
                        if (w_next_oor) begin
                            // Ran off the end of the RAM: terminate with error.
                            w_err_nx   = 1'b1;
                            w_state_nx = S_CLASSIC;
                        end else begin
                            w_ack_nx  = 1'b1;
                            w_rd_en   = 1'b1;
                            w_rd_addr = w_next[c_MA-1:0];
                        end
                    end
                end else begin
                    // Strobe returned after a wait state: re-fetch current beat.
                    w_ack_nx  = 1'b1;
                    w_rd_en   = 1'b1;
                    w_rd_addr = r_baddr[c_MA-1:0];
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Control and read-data registers; reset aborts any transfer at once.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
            r_baddr <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_baddr <= w_baddr_nx;
            r_ack   <= w_ack_nx;
            r_err   <= w_err_nx;
            if (w_rd_en) begin
                r_dat <= r_mem[w_rd_addr];
            end
        end
    end

    // RAM write port; the read address at the same edge is always a different
    // word (successor or re-fetch with no write), so no bypass is required.
    always_ff @(posedge wb_clk_i) begin
        for (int i = 0; i < DW / 8; i++) begin
            if (w_we && wb.wb_sel_i[i]) begin
                r_mem[r_baddr[c_MA-1:0]][8*i +: 8] <= wb.wb_dat_i[8*i +: 8];
            end
        end
    end

    assign wb.wb_dat_o = r_dat;
    assign wb.wb_ack_o = r_ack;
    assign wb.wb_err_o = r_err;
    assign wb.wb_rty_o = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_peripheral_spram_wb_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_peripheral_spram_wb_slave
// Description : Directed self-checking bench for the SPRAM Wishbone responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_peripheral_spram_wb_slave;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 256;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    peripheral_spram_wb_slave_if #(.AW(AW), .DW(DW)) bus ();

    peripheral_spram_wb_slave #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb       (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock; sample/drive 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.wb_adr_i = '0;
        bus.wb_dat_i = '0;
        bus.wb_sel_i = '0;
        bus.wb_we_i  = 1'b0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_cti_i = 3'b000;
        bus.wb_bte_i = 2'b00;
    endtask

    task automatic set_req(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [2:0] cti, input logic [1:0] bte);
        bus.wb_adr_i = adr;
        bus.wb_dat_i = dat;
        bus.wb_sel_i = sel;
        bus.wb_we_i  = we;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_cti_i = cti;
        bus.wb_bte_i = bte;
    endtask

    // One classic transfer; returns what was seen in the termination cycle
    // and whether any termination was still active in the following cycle.
    task automatic classic_xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                                input logic [3:0] sel, output logic ack, output logic err,
                                output logic [31:0] rdat, output logic term_after);
        set_req(adr, we, dat, sel, 3'b000, 2'b00);
        tick();
        ack  = bus.wb_ack_o;
        err  = bus.wb_err_o;
        rdat = bus.wb_dat_o;
        tick();
        idle_bus();
        term_after = bus.wb_ack_o | bus.wb_err_o;
    endtask

    // Four-beat incrementing burst ending with cti=111.
    task automatic burst4(input logic [31:0] adr, input logic we, input logic [1:0] bte,
                          input logic [3:0][31:0] wd, output logic [3:0] acks,
                          output logic [3:0][31:0] rd, output logic term_after);
        set_req(adr, we, wd[0], 4'hF, 3'b010, bte);
        tick();
        for (int i = 0; i < 4; i++) begin
            set_req(adr + 32'(4 * i), we, wd[i], 4'hF, (i == 3) ? 3'b111 : 3'b010, bte);
            acks[i] = bus.wb_ack_o;
            rd[i]   = bus.wb_dat_o;
            tick();
        end
        idle_bus();
        term_after = bus.wb_ack_o | bus.wb_err_o;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_bus();
        tick();
        tick();
        n_tests++;
        if (bus.wb_ack_o !== 1'b0 || bus.wb_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_term: ack=%b err=%b, expected 0 0", bus.wb_ack_o, bus.wb_err_o);
        end
        n_tests++;
        if (bus.wb_dat_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_dat: got %h expected 00000000", bus.wb_dat_o);
        end
        n_tests++;
        if (bus.wb_rty_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rty: got %b expected 0", bus.wb_rty_o);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_classic();
        logic ack, err, term_after;
        logic [31:0] rdat;
        classic_xfer(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, ack, err, rdat, term_after);
        n_tests++;
        if (ack !== 1'b1 || err !== 1'b0 || term_after !== 1'b0) begin
            n_fail++;
            $display("FAIL classic_wr: ack=%b err=%b after=%b expected 1 0 0", ack, err, term_after);
        end
        // Back-to-back reads with the request held: ack, gap, ack.
        set_req(32'h10, 1'b0, 32'h0, 4'hF, 3'b000, 2'b00);
        tick();
        n_tests++;
        if (bus.wb_ack_o !== 1'b1 || bus.wb_dat_o !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL classic_rd1: ack=%b dat=%h expected 1 deadbeef", bus.wb_ack_o, bus.wb_dat_o);
        end
        tick();
        n_tests++;
        if (bus.wb_ack_o !== 1'b0) begin
            n_fail++;
            $display("FAIL classic_gap: ack=%b expected 0", bus.wb_ack_o);
        end
        tick();
        n_tests++;
        if (bus.wb_ack_o !== 1'b1 || bus.wb_dat_o !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL classic_rd2: ack=%b dat=%h expected 1 deadbeef", bus.wb_ack_o, bus.wb_dat_o);
        end
        tick();
        idle_bus();
        n_tests++;
        if (bus.wb_ack_o !== 1'b0) begin
            n_fail++;
            $display("FAIL classic_end: ack=%b expected 0", bus.wb_ack_o);
        end
    endtask

    task automatic test_byte_lane();
        logic ack, err, term_after;
        logic [31:0] rdat;
        classic_xfer(32'h10, 1'b1, 32'h00AA0000, 4'b0100, ack, err, rdat, term_after);
        classic_xfer(32'h10, 1'b0, 32'h0, 4'b0001, ack, err, rdat, term_after);
        n_tests++;
        if (ack !== 1'b1 || rdat !== 32'hDEAABEEF) begin
            n_fail++;
            $display("FAIL byte_lane: ack=%b dat=%h expected 1 deaabeef", ack, rdat);
        end
    endtask

    task automatic test_linear_burst();
        logic [3:0]        acks;
        logic [3:0][31:0]  rd;
        logic              term_after;
        logic [3:0][31:0]  wd;
        wd = {32'd4, 32'd3, 32'd2, 32'd1};
        burst4(32'h40, 1'b1, 2'b00, wd, acks, rd, term_after);
        n_tests++;
        if (acks !== 4'hF || term_after !== 1'b0) begin
            n_fail++;
            $display("FAIL lin_wr: acks=%b after=%b expected 1111 0", acks, term_after);
        end
        burst4(32'h40, 1'b0, 2'b00, '0, acks, rd, term_after);
        n_tests++;
        if (acks !== 4'hF || term_after !== 1'b0) begin
            n_fail++;
            $display("FAIL lin_rd_ack: acks=%b after=%b expected 1111 0", acks, term_after);
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (rd[i] !== wd[i]) begin
                n_fail++;
                $display("FAIL lin_rd_beat%0d: got %h expected %h", i, rd[i], wd[i]);
            end
        end
    endtask

    task automatic test_wrap4();
        logic [3:0]        acks;
        logic [3:0][31:0]  rd;
        logic              term_after;
        logic [3:0][31:0]  exp;
        exp = {32'd2, 32'd1, 32'd4, 32'd3};
        burst4(32'h48, 1'b0, 2'b01, '0, acks, rd, term_after);
        n_tests++;
        if (acks !== 4'hF || term_after !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap4_ack: acks=%b after=%b expected 1111 0", acks, term_after);
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (rd[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL wrap4_beat%0d: got %h expected %h", i, rd[i], exp[i]);
            end
        end
    endtask

    task automatic test_wait_state();
        set_req(32'h40, 1'b0, 32'h0, 4'hF, 3'b010, 2'b00);
        tick();
        n_tests++;
        if (bus.wb_ack_o !== 1'b1 || bus.wb_dat_o !== 32'd1) begin
            n_fail++;
            $display("FAIL ws_beat0: ack=%b dat=%h expected 1 00000001", bus.wb_ack_o, bus.wb_dat_o);
        end
        tick();
        n_tests++;
        if (bus.wb_ack_o !== 1'b1 || bus.wb_dat_o !== 32'd2) begin
            n_fail++;
            $display("FAIL ws_beat1: ack=%b dat=%h expected 1 00000002", bus.wb_ack_o, bus.wb_dat_o);
        end
        tick();
        bus.wb_stb_i = 1'b0;
        tick();
        n_tests++;
        if (bus.wb_ack_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ws_wait1: ack=%b expected 0", bus.wb_ack_o);
        end
        tick();
        n_tests++;
        if (bus.wb_ack_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ws_wait2: ack=%b expected 0", bus.wb_ack_o);
        end
        bus.wb_stb_i = 1'b1;
        tick();
        n_tests++;
        if (bus.wb_ack_o !== 1'b1 || bus.wb_dat_o !== 32'd3) begin
            n_fail++;
            $display("FAIL ws_beat2: ack=%b dat=%h expected 1 00000003", bus.wb_ack_o, bus.wb_dat_o);
        end
        tick();
        bus.wb_cti_i = 3'b111;
        n_tests++;
        if (bus.wb_ack_o !== 1'b1 || bus.wb_dat_o !== 32'd4) begin
            n_fail++;
            $display("FAIL ws_beat3: ack=%b dat=%h expected 1 00000004", bus.wb_ack_o, bus.wb_dat_o);
        end
        tick();
        idle_bus();
        n_tests++;
        if (bus.wb_ack_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ws_end: ack=%b expected 0", bus.wb_ack_o);
        end
    endtask

    task automatic test_out_of_range();
        logic ack, err, term_after;
        logic [31:0] rdat;
        classic_xfer(32'h0, 1'b1, 32'h11111111, 4'hF, ack, err, rdat, term_after);
        classic_xfer(32'h400, 1'b1, 32'h12345678, 4'hF, ack, err, rdat, term_after);
        n_tests++;
        if (err !== 1'b1 || ack !== 1'b0 || term_after !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_classic: ack=%b err=%b after=%b expected 0 1 0", ack, err, term_after);
        end
        // Linear burst from word 254 runs into word 256 on its third beat.
        set_req(32'h3F8, 1'b1, 32'hA0, 4'hF, 3'b010, 2'b00);
        tick();
        n_tests++;
        if (bus.wb_ack_o !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_burst_b0: ack=%b expected 1", bus.wb_ack_o);
        end
        tick();
        set_req(32'h3FC, 1'b1, 32'hA1, 4'hF, 3'b010, 2'b00);
        n_tests++;
        if (bus.wb_ack_o !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_burst_b1: ack=%b expected 1", bus.wb_ack_o);
        end
        tick();
        set_req(32'h400, 1'b1, 32'hA2, 4'hF, 3'b010, 2'b00);
        n_tests++;
        if (bus.wb_err_o !== 1'b1 || bus.wb_ack_o !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_burst_err: ack=%b err=%b expected 0 1", bus.wb_ack_o, bus.wb_err_o);
        end
        tick();
        n_tests++;
        if (bus.wb_err_o !== 1'b0 || bus.wb_ack_o !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_burst_end: ack=%b err=%b expected 0 0", bus.wb_ack_o, bus.wb_err_o);
        end
        idle_bus();
        tick();
        classic_xfer(32'h0, 1'b0, 32'h0, 4'hF, ack, err, rdat, term_after);
        n_tests++;
        if (rdat !== 32'h11111111) begin
            n_fail++;
            $display("FAIL oor_word0_intact: got %h expected 11111111", rdat);
        end
        classic_xfer(32'h3F8, 1'b0, 32'h0, 4'hF, ack, err, rdat, term_after);
        n_tests++;
        if (rdat !== 32'hA0) begin
            n_fail++;
            $display("FAIL oor_word254: got %h expected 000000a0", rdat);
        end
        classic_xfer(32'h3FC, 1'b0, 32'h0, 4'hF, ack, err, rdat, term_after);
        n_tests++;
        if (rdat !== 32'hA1) begin
            n_fail++;
            $display("FAIL oor_word255: got %h expected 000000a1", rdat);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic ack, err, term_after;
        logic [31:0] rdat;
        set_req(32'h40, 1'b1, 32'hBAD0BAD0, 4'hF, 3'b010, 2'b00);
        tick();
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.wb_ack_o !== 1'b0 || bus.wb_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: ack=%b err=%b expected 0 0", bus.wb_ack_o, bus.wb_err_o);
        end
        tick();
        n_tests++;
        if (bus.wb_ack_o !== 1'b0 || bus.wb_dat_o !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_hold: ack=%b dat=%h expected 0 00000000", bus.wb_ack_o, bus.wb_dat_o);
        end
        idle_bus();
        rst = 1'b0;
        tick();
        classic_xfer(32'h40, 1'b0, 32'h0, 4'hF, ack, err, rdat, term_after);
        n_tests++;
        if (ack !== 1'b1 || rdat !== 32'd1) begin
            n_fail++;
            $display("FAIL rst_mem_40: ack=%b dat=%h expected 1 00000001", ack, rdat);
        end
        classic_xfer(32'h10, 1'b0, 32'h0, 4'hF, ack, err, rdat, term_after);
        n_tests++;
        if (rdat !== 32'hDEAABEEF) begin
            n_fail++;
            $display("FAIL rst_mem_10: got %h expected deaabeef", rdat);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        idle_bus();
        test_reset();
        test_classic();
        test_byte_lane();
        test_linear_burst();
        test_wrap4();
        test_wait_state();
        test_out_of_range();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
